// File: rtl/ring_router_demux_if.sv
// DI channel bundle between ring router stages: one flit per valid&ready
// handshake, with first/last marking worm boundaries.
interface ring_router_demux_if #(
    parameter int WIDTH = 16
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             first;
    logic             last;

    modport master (output valid, output data, output first, output last, input ready);
    modport slave  (input valid, input data, input first, input last, output ready);
endinterface

// File: rtl/ring_router_demux.sv
// Input-side steering stage of the debug ring router. Each worm arriving
// from upstream is sent whole either to the local port (head word == id_i)
// or onward to the ring output mux.
//
// Build option: RING_ROUTER_DEMUX_REG_EN inserts a 2-entry skid buffer in
// front of the steering logic, breaking every combinational path between
// the upstream and downstream ports. Undefined: fully combinational path.
//
// state      | meaning
// NOWORM     | between worms; next valid flit must be a head
// WORM_LOCAL | inside a worm addressed to this router
// WORM_RING  | inside a worm passing through to the ring
module ring_router_demux #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           id_i,
    ring_router_demux_if.slave         in_i,
    ring_router_demux_if.master        out_local_o,
    ring_router_demux_if.master        out_ring_o
);

    typedef enum logic [1:0] {
        NOWORM     = 2'd0,
        WORM_LOCAL = 2'd1,
        WORM_RING  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Stream seen by the steering logic (either straight from in_i or from
    // the head of the skid buffer).
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_first;
    logic             s_last;

    logic             sel_local;
    logic             sel_ring;
    logic             head_local;

`ifdef RING_ROUTER_DEMUX_REG_EN
    localparam int ENTRY_W = WIDTH + 2;

    logic [ENTRY_W-1:0] mem_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         cnt_q, cnt_d;
    logic               rdy_q;
    logic               push;
    logic               pop;

    assign push       = in_i.valid & rdy_q;
    assign pop        = s_valid & s_ready;
    assign s_valid    = (cnt_q != 2'd0);
    assign {s_data, s_first, s_last} = mem_q[rd_ptr_q];
    assign in_i.ready = rdy_q;

    // Occupancy after this cycle's enqueue/dequeue.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Buffer pointers, occupancy and the registered upstream ready; ready
    // is computed from next occupancy so a full buffer that drains this
    // cycle reopens immediately on the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != 2'd2);
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Buffer storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_i.data, in_i.first, in_i.last};
    end
`else
    assign s_valid    = in_i.valid;
    assign s_data     = in_i.data;
    assign s_first    = in_i.first;
    assign s_last     = in_i.last;
    assign in_i.ready = s_ready;
`endif

    assign head_local = (s_data == id_i);

    // Worm state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= NOWORM;
        else     state_q <= state_d;
    end

    // Output selection, upstream ready and worm tracking. In NOWORM a
    // non-head flit is swallowed (ready=1, no output selected). Everything
    // is forced idle while reset is held.
    always_comb begin
        state_d   = state_q;
        sel_local = 1'b0;
        sel_ring  = 1'b0;
        s_ready   = 1'b0;
        if (!rst) begin
            case (state_q)
                NOWORM: begin
                    if (s_first) begin
                        if (head_local) begin
                            sel_local = 1'b1;
                            s_ready   = out_local_o.ready;
                        end else begin
                            sel_ring  = 1'b1;
                            s_ready   = out_ring_o.ready;
                        end
                        if (s_valid && s_ready && !s_last)
                            state_d = head_local ? WORM_LOCAL : WORM_RING;
                    end else begin
                        s_ready = 1'b1;
                    end
                end
                WORM_LOCAL: begin
                    sel_local = 1'b1;
                    s_ready   = out_local_o.ready;
                    if (s_valid && s_ready && s_last) state_d = NOWORM;
                end
                WORM_RING: begin
                    sel_ring = 1'b1;
                    s_ready  = out_ring_o.ready;
                    if (s_valid && s_ready && s_last) state_d = NOWORM;
                end
                default: state_d = NOWORM;
            endcase
        end
    end

    assign out_local_o.valid = s_valid & sel_local;
    assign out_local_o.data  = s_data;
    assign out_local_o.first = s_first;
    assign out_local_o.last  = s_last;

    assign out_ring_o.valid  = s_valid & sel_ring;
    assign out_ring_o.data   = s_data;
    assign out_ring_o.first  = s_first;
    assign out_ring_o.last   = s_last;

endmodule

// File: tb/tb_ring_router_demux.sv
// Bench for ring_router_demux (default, combinational build): a table of
// single-cycle vectors, hand-written worm sequences, and per-output
// scoreboards that check every delivered flit in order.
module tb_ring_router_demux;

    localparam int WIDTH = 16;

    typedef enum int {D_LOCAL, D_RING, D_DROP} dest_t;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        f;
        logic        l;
        logic        lr;
        logic        rr;
        logic [15:0] idv;
        logic        elv;
        logic        erv;
        logic        eir;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] id;

    ring_router_demux_if #(.WIDTH(WIDTH)) in_if   ();
    ring_router_demux_if #(.WIDTH(WIDTH)) loc_if  ();
    ring_router_demux_if #(.WIDTH(WIDTH)) ring_if ();

    ring_router_demux #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_i        (id),
        .in_i        (in_if),
        .out_local_o (loc_if),
        .out_ring_o  (ring_if)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [17:0] q_loc[$];
    logic [17:0] q_ring[$];
    logic [17:0] e_loc;
    logic [17:0] e_ring;
    int          mstate = 0;   // 0 between worms, 1 local worm, 2 ring worm
    vec_t        vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each flit that transfers on an output must be the next
    // one expected for that output.
    always @(negedge clk) begin
        if (!rst && loc_if.valid && loc_if.ready) begin
            n_checks++;
            if (q_loc.size() == 0) begin
                n_fail++;
                $display("FAIL local_unexpected: got %h, expected no flit", {loc_if.data, loc_if.first, loc_if.last});
            end else begin
                e_loc = q_loc.pop_front();
                if ({loc_if.data, loc_if.first, loc_if.last} !== e_loc) begin
                    n_fail++;
                    $display("FAIL local_flit: got %h, expected %h", {loc_if.data, loc_if.first, loc_if.last}, e_loc);
                end
            end
        end
        if (!rst && ring_if.valid && ring_if.ready) begin
            n_checks++;
            if (q_ring.size() == 0) begin
                n_fail++;
                $display("FAIL ring_unexpected: got %h, expected no flit", {ring_if.data, ring_if.first, ring_if.last});
            end else begin
                e_ring = q_ring.pop_front();
                if ({ring_if.data, ring_if.first, ring_if.last} !== e_ring) begin
                    n_fail++;
                    $display("FAIL ring_flit: got %h, expected %h", {ring_if.data, ring_if.first, ring_if.last}, e_ring);
                end
            end
        end
    end

    // Drive one flit (called just after a rising edge), expect it on the
    // model's destination in the same cycle, wait for the handshake, and
    // return just after the edge on which it transferred.
    task automatic send_flit(input logic [15:0] d, input logic f, input logic l);
        dest_t dst;
        bit    done;
        if (mstate == 0) dst = f ? ((d == id) ? D_LOCAL : D_RING) : D_DROP;
        else             dst = (mstate == 1) ? D_LOCAL : D_RING;
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.first = f;
        in_if.last  = l;
        if (dst == D_LOCAL)     q_loc.push_back({d, f, l});
        else if (dst == D_RING) q_ring.push_back({d, f, l});
        #1;
        case (dst)
            D_LOCAL: check($sformatf("route_local_%h", d), {30'd0, ring_if.valid, loc_if.valid}, 32'd1);
            D_RING:  check($sformatf("route_ring_%h", d),  {30'd0, ring_if.valid, loc_if.valid}, 32'd2);
            default: check($sformatf("drop_%h", d), {29'd0, ring_if.valid, loc_if.valid, in_if.ready}, 32'd1);
        endcase
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_if.ready) done = 1'b1;
            else @(posedge clk);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: flit %h not accepted, expected accept within 50 cycles", d);
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        if (mstate == 0) begin
            if (f && !l) mstate = (dst == D_LOCAL) ? 1 : 2;
        end else if (l) begin
            mstate = 0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          v     d        f     l     lr    rr    id       elv   erv   eir
        vecs[0] = '{1'b1, 16'h0005, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 16'h0007, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h0007, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 16'h0009, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0009, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst            = 1'b1;
        id             = 16'h0005;
        in_if.valid    = 1'b1;
        in_if.data     = 16'h0005;
        in_if.first    = 1'b1;
        in_if.last     = 1'b1;
        loc_if.ready   = 1'b1;
        ring_if.ready  = 1'b1;

        // Reset holds everything idle even with a head presented.
        @(posedge clk); #1;
        check("reset_idle", {29'd0, loc_if.valid, ring_if.valid, in_if.ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b0;
        in_if.valid = 1'b0;
        #1;
        check("idle_after_reset", {30'd0, loc_if.valid, ring_if.valid}, 32'd0);
        @(posedge clk); #1;

        // Single-cycle routing vectors in NOWORM.
        for (int i = 0; i < 8; i++) begin
            in_if.valid   = vecs[i].v;
            in_if.data    = vecs[i].d;
            in_if.first   = vecs[i].f;
            in_if.last    = vecs[i].l;
            loc_if.ready  = vecs[i].lr;
            ring_if.ready = vecs[i].rr;
            id            = vecs[i].idv;
            if (vecs[i].elv && vecs[i].lr) q_loc.push_back({vecs[i].d, vecs[i].f, vecs[i].l});
            if (vecs[i].erv && vecs[i].rr) q_ring.push_back({vecs[i].d, vecs[i].f, vecs[i].l});
            #1;
            check($sformatf("vec%0d_local_valid", i), {31'd0, loc_if.valid},  {31'd0, vecs[i].elv});
            check($sformatf("vec%0d_ring_valid", i),  {31'd0, ring_if.valid}, {31'd0, vecs[i].erv});
            check($sformatf("vec%0d_in_ready", i),    {31'd0, in_if.ready},   {31'd0, vecs[i].eir});
            if (vecs[i].elv) check($sformatf("vec%0d_local_data", i), {16'd0, loc_if.data},  {16'd0, vecs[i].d});
            if (vecs[i].erv) check($sformatf("vec%0d_ring_data", i),  {16'd0, ring_if.data}, {16'd0, vecs[i].d});
            @(posedge clk); #1;
        end
        in_if.valid   = 1'b0;
        loc_if.ready  = 1'b1;
        ring_if.ready = 1'b1;
        id            = 16'h0005;

        // 3-flit local worm.
        send_flit(16'h0005, 1'b1, 1'b0);
        send_flit(16'h00A1, 1'b0, 1'b0);
        send_flit(16'h00A2, 1'b0, 1'b1);

        // Back-to-back single-flit worms: ring then local.
        send_flit(16'h0007, 1'b1, 1'b1);
        send_flit(16'h0005, 1'b1, 1'b1);

        // 4-flit ring worm with ring back-pressure in cycles 2-4 while the
        // local ready toggles.
        fork
            begin
                send_flit(16'h0020, 1'b1, 1'b0);
                send_flit(16'h0021, 1'b0, 1'b0);
                send_flit(16'h0022, 1'b0, 1'b0);
                send_flit(16'h0023, 1'b0, 1'b1);
            end
            begin
                @(posedge clk);
                for (int k = 0; k < 3; k++) begin
                    #1;
                    ring_if.ready = 1'b0;
                    loc_if.ready  = ~loc_if.ready;
                    #1;
                    check($sformatf("stall_in_ready_%0d", k), {31'd0, in_if.ready}, 32'd0);
                    @(posedge clk);
                end
                #1;
                ring_if.ready = 1'b1;
                loc_if.ready  = 1'b1;
            end
        join

        // Stray non-head flit is dropped, then a proper head routes.
        send_flit(16'h0033, 1'b0, 1'b0);
        send_flit(16'h0007, 1'b1, 1'b1);

        // Reset during the 2nd flit of a local worm.
        send_flit(16'h0005, 1'b1, 1'b0);
        rst         = 1'b1;
        in_if.valid = 1'b1;
        in_if.data  = 16'h0051;
        in_if.first = 1'b0;
        in_if.last  = 1'b0;
        #1;
        check("reset_mid_worm", {29'd0, loc_if.valid, ring_if.valid, in_if.ready}, 32'd0);
        @(posedge clk); #1;
        check("reset_mid_worm_hold", {29'd0, loc_if.valid, ring_if.valid, in_if.ready}, 32'd0);
        @(posedge clk); #1;
        rst         = 1'b0;
        in_if.valid = 1'b0;
        mstate      = 0;
        send_flit(16'h000B, 1'b1, 1'b0);
        send_flit(16'h00B1, 1'b0, 1'b1);

        // id changes mid-worm: remainder stays local, next head uses new id.
        send_flit(16'h0005, 1'b1, 1'b0);
        id = 16'h0009;
        send_flit(16'h0061, 1'b0, 1'b0);
        send_flit(16'h0062, 1'b0, 1'b1);
        send_flit(16'h0005, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("local_queue_drained", q_loc.size(), 32'd0);
        check("ring_queue_drained",  q_ring.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
